// File: rtl/pixel_pkg.sv
// Shared types for the RGB111 pixel transmit path.
package pixel_pkg;

    typedef logic [2:0] pixel_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: rd_data always shows the head entry.
module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    // full is judged before any same-cycle pop, so a pop never makes room for a write
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_stream_tx.sv
// Streams buffered RGB111 pixels as one framed H_ACTIVE x V_ACTIVE frame per start pulse.
module pixel_stream_tx
    import pixel_pkg::*;
#(
    parameter int H_ACTIVE = 8,
    parameter int V_ACTIVE = 4,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr_en,
    input  logic [2:0] wr_data,
    output logic       full,
    output logic       overflow,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [2:0] tx_data,
    output logic       tx_sof,
    output logic       tx_eol,
    output logic       frame_done,
    output logic       busy
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    tx_state_t     state_q;
    tx_state_t     state_d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    pixel_t        head;
    logic          empty;
    logic          transfer;
    logic          last_pixel;

    assign transfer   = tx_valid && tx_ready;
    assign last_pixel = (x == X_LAST) && (y == Y_LAST);

    sync_fifo #(
        .WIDTH (3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (transfer),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // tx_data is forced to zero while not valid so the unreset FIFO storage never leaks out
    always_comb begin
        state_d    = state_q;
        tx_valid   = 1'b0;
        tx_data    = 3'b000;
        tx_sof     = 1'b0;
        tx_eol     = 1'b0;
        busy       = (state_q != IDLE);
        frame_done = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                tx_valid = !empty;
                tx_data  = empty ? 3'b000 : head;
                tx_sof   = !empty && (x == '0) && (y == '0);
                tx_eol   = !empty && (x == X_LAST);
                if (transfer && last_pixel) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (transfer) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end

endmodule
